memory_access_unit: RTL and testbench

MEMORY_ACCESS_UNIT -- requirements
Module: memory_access_unit

---
 rtl/memory_access_unit.sv | 189 ++++++++++++++++++
 tb/tb_memory_access_unit.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_unit.sv
// Load/store unit between the control unit and a word-wide synchronous memory.
// It checks alignment, steers byte/halfword lanes and extends loaded data.
package memory_access_unit_pkg;
  typedef enum logic [2:0] {mt_x = 3'd0, mt_b, mt_bu, mt_h, mt_hu, mt_w} mask_t;
  typedef enum logic [1:0] {me_x = 2'd0, me_rd = 2'd1, me_wr = 2'd2} req_t;
  typedef struct packed {
    logic [31:0] addrin;
    logic [31:0] datain;
    mask_t       mask;
    req_t        req;
  } CUtoME_IF;
  typedef struct packed {
    logic [31:0] loadeddata;
  } MEtoCU_IF;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, READ_DATA = 2'd2, RESP = 2'd3} state_t;
endpackage

module memory_access_unit
  import memory_access_unit_pkg::*;
#(
  parameter int ADDR_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  CUtoME_IF             cu_req_data,
  input  logic                 cu_req_sync,
  output logic                 cu_req_notify,
  output MEtoCU_IF             me_resp_data,
  output logic                 me_resp_notify,
  input  logic                 me_resp_sync,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_BITS-3:0] mem_addr,
  output logic [3:0]           mem_be,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata,
  output logic                 misalign_err,
  output state_t               dbg_state_o
);

  // Handshakes: a request transfers on a rising edge where cu_req_sync and
  // cu_req_notify are both 1; a response transfers on an edge where
  // me_resp_notify and me_resp_sync are both 1. Data is stable while notify=1.

  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [31:0]            data_q, data_d;
  mask_t                  mask_q, mask_d;
  req_t                   req_q, req_d;
  logic [31:0]            load_q, load_d;

  logic                   is_rd, is_wr, aligned;
  logic [3:0]             lane_be;
  logic [7:0]             rd_byte;
  logic [15:0]            rd_half;
  logic [31:0]            rd_ext;
  logic                   unused_addr_hi;

  // Address bits above ADDR_BITS wrap away and are intentionally dropped.
  assign unused_addr_hi = ^cu_req_data.addrin[31:ADDR_BITS];

  assign is_rd = (req_q == me_rd);
  assign is_wr = (req_q == me_wr);

  always_comb begin
    aligned   = 1'b0;
    lane_be   = 4'b0000;
    mem_wdata = data_q;
    case (mask_q)
      mt_b, mt_bu: begin
        aligned   = 1'b1;
        lane_be   = 4'b0001 << addr_q[1:0];
        mem_wdata = {4{data_q[7:0]}};
      end
      mt_h, mt_hu: begin
        aligned   = ~addr_q[0];
        lane_be   = addr_q[1] ? 4'b1100 : 4'b0011;
        mem_wdata = {2{data_q[15:0]}};
      end
      mt_w: begin
        aligned   = (addr_q[1:0] == 2'b00);
        lane_be   = 4'b1111;
        mem_wdata = data_q;
      end
      default: begin
        aligned   = 1'b0;
        lane_be   = 4'b0000;
        mem_wdata = data_q;
      end
    endcase
  end

  assign rd_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign rd_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    case (mask_q)
      mt_b:    rd_ext = {{24{rd_byte[7]}}, rd_byte};
      mt_bu:   rd_ext = {24'h000000, rd_byte};
      mt_h:    rd_ext = {{16{rd_half[15]}}, rd_half};
      mt_hu:   rd_ext = {16'h0000, rd_half};
      default: rd_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    data_d         = data_q;
    mask_d         = mask_q;
    req_d          = req_q;
    load_d         = load_q;
    cu_req_notify  = 1'b0;
    me_resp_notify = 1'b0;
    mem_en         = 1'b0;
    mem_we         = 1'b0;
    mem_be         = 4'b0000;
    misalign_err   = 1'b0;
    case (state_q)
      IDLE: begin
        cu_req_notify = 1'b1;
        if (cu_req_sync) begin
          addr_d  = cu_req_data.addrin[ADDR_BITS-1:0];
          data_d  = cu_req_data.datain;
          mask_d  = cu_req_data.mask;
          req_d   = cu_req_data.req;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!is_rd && !is_wr) begin
          state_d = IDLE;
        end else if (!aligned) begin
          // An illegal read still answers, with zero data, so the CU never stalls.
          misalign_err = 1'b1;
          if (is_rd) begin
            load_d  = 32'h0;
            state_d = RESP;
          end else begin
            state_d = IDLE;
          end
        end else begin
          mem_en = 1'b1;
          mem_we = is_wr;
          if (is_wr) begin
            mem_be  = lane_be;
            state_d = IDLE;
          end else begin
            state_d = READ_DATA;
          end
        end
      end
      READ_DATA: begin
        load_d  = rd_ext;
        state_d = RESP;
      end
      RESP: begin
        me_resp_notify = 1'b1;
        if (me_resp_sync) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= mt_x;
      req_q   <= me_x;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      req_q   <= req_d;
      load_q  <= load_d;
    end
  end

  assign mem_addr                = addr_q[ADDR_BITS-1:2];
  assign me_resp_data.loadeddata = load_q;
  assign dbg_state_o             = state_q;

endmodule

// File: tb/tb_memory_access_unit.sv
// Randomized scoreboard bench for memory_access_unit against a byte-addressed
// reference memory; directed cases cover alignment errors, stalls and reset.
module tb_memory_access_unit;
  import memory_access_unit_pkg::*;

  logic        clk;
  logic        rst;
  CUtoME_IF    cu_req_data;
  logic        cu_req_sync;
  logic        cu_req_notify;
  MEtoCU_IF    me_resp_data;
  logic        me_resp_notify;
  logic        me_resp_sync;
  logic        mem_en;
  logic        mem_we;
  logic [13:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        misalign_err;
  state_t      dbg_state_o;

  memory_access_unit #(.ADDR_BITS(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .cu_req_data    (cu_req_data),
    .cu_req_sync    (cu_req_sync),
    .cu_req_notify  (cu_req_notify),
    .me_resp_data   (me_resp_data),
    .me_resp_notify (me_resp_notify),
    .me_resp_sync   (me_resp_sync),
    .mem_en         (mem_en),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_be         (mem_be),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .misalign_err   (misalign_err),
    .dbg_state_o    (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];       // load responses
  logic [50:0] exp_mem_q[$];   // {we, word addr, be, wdata}
  logic [31:0] err_q[$];       // addresses of expected misalign pulses
  logic [7:0]  ref_mem [int];  // byte-addressed reference memory

  int  fixed_hold = 0;
  bit  rand_hold  = 1'b0;
  int  wait_cnt   = 0;
  int  cur_hold   = 0;
  bit  accepted_prev = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- synchronous SRAM model ----------------
  logic [31:0] sram [0:16383];
  initial begin
    for (int i = 0; i < 16384; i++) sram[i] = 32'h0;
    mem_rdata = 32'h0;
  end
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int k = 0; k < 4; k++)
          if (mem_be[k]) sram[mem_addr][8*k +: 8] <= mem_wdata[8*k +: 8];
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] rb(input logic [15:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return 8'h00;
  endfunction

  function automatic int access_size(input mask_t m);
    case (m)
      mt_b, mt_bu: return 1;
      mt_h, mt_hu: return 2;
      mt_w:        return 4;
      default:     return 0;
    endcase
  endfunction

  task automatic model(input req_t r, input mask_t m, input logic [31:0] a, input logic [31:0] d);
    logic [15:0] base;
    int          sz;
    bit          legal;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] v;
    base = a[15:0];
    sz   = access_size(m);
    legal = (sz == 1) || (sz == 2 && base[0] == 1'b0) || (sz == 4 && base[1:0] == 2'b00);
    if (r == me_x) return;
    if (!legal) begin
      err_q.push_back(a);
      if (r == me_rd) exp_q.push_back(32'h0);
      return;
    end
    if (r == me_wr) begin
      be = 4'b0000;
      for (int i = 0; i < sz; i++) begin
        ref_mem[int'(base) + i] = d[8*i +: 8];
        be[(int'(base) + i) % 4] = 1'b1;
      end
      wd = (sz == 1) ? {4{d[7:0]}} : (sz == 2) ? {2{d[15:0]}} : d;
      exp_mem_q.push_back({1'b1, base[15:2], be, wd});
    end else begin
      v = 32'h0;
      for (int i = 0; i < sz; i++) v[8*i +: 8] = rb(base + 16'(i));
      if (m == mt_b) v = {{24{v[7]}}, v[7:0]};
      if (m == mt_h) v = {{16{v[15]}}, v[15:0]};
      exp_mem_q.push_back({1'b0, base[15:2], 4'b0000, 32'h0});
      exp_q.push_back(v);
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_req(input req_t r, input mask_t m, input logic [31:0] a,
                        input logic [31:0] d, input bit track);
    int n;
    n = 0;
    @(negedge clk);
    while (!cu_req_notify && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cu_req_notify) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: cu_req_notify stuck at 0, expected 1 within 50 cycles");
      return;
    end
    cu_req_data.addrin = a;
    cu_req_data.datain = d;
    cu_req_data.mask   = m;
    cu_req_data.req    = r;
    cu_req_sync        = 1'b1;
    if (track) model(r, m, a, d);
    @(posedge clk);
    #1 cu_req_sync = 1'b0;
  endtask

  // Response acceptor: hold off me_resp_sync for cur_hold cycles of notify.
  always @(posedge clk) begin
    #1;
    if (rst && me_resp_notify) begin
      me_resp_sync = (wait_cnt >= cur_hold);
      wait_cnt++;
    end else begin
      me_resp_sync = 1'b0;
      wait_cnt     = 0;
      cur_hold     = rand_hold ? int'($urandom_range(0, 3)) : fixed_hold;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      accepted_prev = 1'b0;
    end else begin
      if (accepted_prev) begin
        check32("idle_after_accept", {30'b0, dbg_state_o}, {30'b0, IDLE});
        check32("notify_after_accept", {31'b0, cu_req_notify}, 32'd1);
      end
      if (mem_en) begin
        if (exp_mem_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_mem: mem_en=1 addr=0x%04h, expected no access", mem_addr);
        end else begin
          logic [50:0] e;
          e = exp_mem_q.pop_front();
          check32("mem_we", {31'b0, mem_we}, {31'b0, e[50]});
          check32("mem_addr", {18'b0, mem_addr}, {18'b0, e[49:36]});
          if (e[50]) begin
            check32("mem_be", {28'b0, mem_be}, {28'b0, e[35:32]});
            check32("mem_wdata", mem_wdata, e[31:0]);
          end
        end
      end else begin
        check32("idle_lanes", {27'b0, mem_we, mem_be}, 32'h0);
      end
      if (misalign_err) begin
        check32("err_no_mem", {31'b0, mem_en}, 32'd0);
        if (err_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_err: misalign_err=1, expected 0");
        end else begin
          void'(err_q.pop_front());
        end
      end
      if (me_resp_notify) begin
        check32("busy_notify", {31'b0, cu_req_notify}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: data=0x%08h, expected no response", me_resp_data.loadeddata);
        end else begin
          check32("resp_data", me_resp_data.loadeddata, exp_q[0]);
          if (me_resp_sync) void'(exp_q.pop_front());
        end
      end
      accepted_prev = me_resp_notify && me_resp_sync;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    rst         = 1'b0;
    cu_req_sync = 1'b0;
    me_resp_sync = 1'b0;
    cu_req_data = '0;
    #1;
    check32("rst_outputs", {26'b0, mem_en, mem_we, me_resp_notify, misalign_err, dbg_state_o},
            {26'b0, 6'b000000});
    check32("rst_req_notify", {31'b0, cu_req_notify}, 32'd1);
    check32("rst_resp_data", me_resp_data.loadeddata, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    do_req(me_wr, mt_w,  32'h0000_0100, 32'hDEADBEEF, 1'b1);
    do_req(me_rd, mt_b,  32'h0000_0103, 32'h0, 1'b1);
    do_req(me_rd, mt_bu, 32'h0000_0103, 32'h0, 1'b1);
    do_req(me_rd, mt_h,  32'h0000_0102, 32'h0, 1'b1);
    do_req(me_rd, mt_hu, 32'h0000_0102, 32'h0, 1'b1);

    // Reset while the untracked read sits in ACCESS.
    do_req(me_rd, mt_w, 32'h0000_0100, 32'h0, 1'b0);
    rst = 1'b0;
    #1;
    check32("rst_access_mem_en", {31'b0, mem_en}, 32'd0);
    check32("rst_access_resp", {31'b0, me_resp_notify}, 32'd0);
    check32("rst_access_state", {30'b0, dbg_state_o}, {30'b0, IDLE});
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Response appears two edges after the accept edge: the fourth cycle of a read.
    do_req(me_rd, mt_w, 32'h0000_0100, 32'h0, 1'b1);
    n = 0;
    while (!me_resp_notify && n < 10) begin
      @(posedge clk);
      #1 n++;
    end
    check32("read_latency", n, 32'd2);

    do_req(me_wr, mt_b,  32'h0000_0101, 32'h0000_005A, 1'b1);
    do_req(me_wr, mt_h,  32'h0000_0101, 32'h0000_1234, 1'b1);
    do_req(me_rd, mt_w,  32'h0000_0102, 32'h0, 1'b1);
    do_req(me_rd, mt_x,  32'h0000_0100, 32'h0, 1'b1);
    do_req(me_x,  mt_w,  32'h0000_0100, 32'h0, 1'b1);

    fixed_hold = 5;
    do_req(me_rd, mt_w, 32'h0000_0100, 32'h0, 1'b1);
    repeat (10) @(negedge clk);
    fixed_hold = 0;

    do_req(me_rd, mt_w, 32'h0001_0104, 32'h0, 1'b1);
    do_req(me_wr, mt_w, 32'hFFFF_0104, 32'h0BADF00D, 1'b1);
    do_req(me_rd, mt_hu, 32'h0000_0106, 32'h0, 1'b1);

    rand_hold = 1'b1;
    for (int i = 0; i < 200; i++) begin
      req_t        r;
      mask_t       m;
      logic [31:0] a;
      r = req_t'($urandom_range(0, 2));
      m = mask_t'($urandom_range(0, 5));
      a = {16'($urandom), 16'h0100 + 16'($urandom_range(0, 31))};
      do_req(r, m, a, $urandom, 1'b1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    n = 0;
    while ((exp_q.size() != 0 || exp_mem_q.size() != 0 || err_q.size() != 0 ||
            dbg_state_o != IDLE) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check32("drain_resp", exp_q.size(), 32'd0);
    check32("drain_mem", exp_mem_q.size(), 32'd0);
    check32("drain_err", err_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
